// File: rtl/rotate_ship.sv
// Ship heading controller: buttons -> wrapping heading index -> registered Q1.17 sin/cos.
// Optional build macro ROTATE_AUTO_ACCEL_EN enables double-speed rotation after sustained holds.
module rotate_ship #(
   parameter int ANGLE_BITS = 6,
   parameter int BTN_RATE   = 20,
   parameter int DIVIDER    = 125_000,
   parameter int CLK_RATE   = 25_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  collision,
   input  logic                  left,
   input  logic                  right,
   output logic [ANGLE_BITS-1:0] angle,
   output logic signed [17:0]    sin_val,
   output logic signed [17:0]    cos_val,
   output logic                  trig_valid
);

   localparam int STEP_DIV = CLK_RATE / DIVIDER / BTN_RATE;
   localparam int TW       = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam int SW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int IW       = ANGLE_BITS - 2;
   localparam int IW1      = IW + 1;
   localparam int Q        = 2 ** IW;
   localparam longint PI_FX = 64'sd3373259426;

   // Quarter-wave sine table from a Taylor series in 2^30 fixed point (integer only).
   function automatic logic [(Q+1)*17-1:0] build_tbl();
      logic [(Q+1)*17-1:0] v;
      longint x, x2, term, acc, r;
      v = '0;
      for (int k = 0; k <= Q; k++) begin
         x    = (longint'(k) * PI_FX) / longint'(2 * Q);
         x2   = (x * x) >>> 30;
         term = x;
         acc  = x;
         for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> 30) / (longint'(2 * n) * longint'(2 * n + 1));
            acc  = acc + term;
         end
         r = (acc * 64'sd131072 + (64'sd1 <<< 29)) >>> 30;
         if (r > 64'sd131071) r = 64'sd131071;
         if (r < 64'sd0) r = 64'sd0;
         v[k*17 +: 17] = r[16:0];
      end
      return v;
   endfunction

   localparam logic [(Q+1)*17-1:0] TBL = build_tbl();

   logic [TW-1:0]         r_tick;
   logic [SW-1:0]         r_step;
   logic [ANGLE_BITS-1:0] r_angle;
   logic                  r_angle_chg;
   logic [1:0]            r_s1_quad;
   logic [16:0]           r_s1_a;
   logic [16:0]           r_s1_b;
   logic                  r_s1_chg;
   logic signed [17:0]    r_sin;
   logic signed [17:0]    r_cos;
   logic                  r_valid;

   logic                  w_step_tick;
   logic                  w_one;
   logic [ANGLE_BITS-1:0] w_delta;
   logic [ANGLE_BITS-1:0] w_next;
   logic [IW-1:0]         w_i;
   logic [IW1-1:0]        w_qi;
   logic [16:0]           w_a;
   logic [16:0]           w_b;
   logic signed [17:0]    w_pa;
   logic signed [17:0]    w_pb;
   logic signed [17:0]    w_sin;
   logic signed [17:0]    w_cos;

   assign w_step_tick = (r_tick == TW'(DIVIDER - 1)) && (r_step == SW'(STEP_DIV - 1));
   assign w_one       = left ^ right;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick <= '0;
         r_step <= '0;
      end else if (r_tick == TW'(DIVIDER - 1)) begin
         r_tick <= '0;
         r_step <= (r_step == SW'(STEP_DIV - 1)) ? '0 : r_step + SW'(1);
      end else begin
         r_tick <= r_tick + TW'(1);
      end
   end

`ifdef ROTATE_AUTO_ACCEL_EN
   logic [1:0] r_rep;

   // Counts consecutive single-button steps; saturates at 3, where the step doubles.
   always_ff @(posedge clk) begin
      if (reset || collision) begin
         r_rep <= 2'd0;
      end else if (w_step_tick) begin
         if (!w_one) r_rep <= 2'd0;
         else if (r_rep != 2'd3) r_rep <= r_rep + 2'd1;
      end
   end

   assign w_delta = (r_rep == 2'd3) ? ANGLE_BITS'(2) : ANGLE_BITS'(1);
`else
   assign w_delta = ANGLE_BITS'(1);
`endif

   always_comb begin
      w_next = r_angle;
      if (collision) w_next = '0;
      else if (w_step_tick && w_one) w_next = left ? r_angle + w_delta : r_angle - w_delta;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_angle     <= '0;
         r_angle_chg <= 1'b0;
      end else begin
         r_angle     <= w_next;
         r_angle_chg <= (w_next != r_angle);
      end
   end

   assign w_i  = r_angle[IW-1:0];
   assign w_qi = IW1'(Q) - {1'b0, w_i};
   assign w_a  = TBL[int'(w_i) * 17 +: 17];
   assign w_b  = TBL[int'(w_qi) * 17 +: 17];

   // trig_valid is a one-cycle strobe with no back-pressure; sin_val/cos_val hold between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_quad <= 2'd0;
         r_s1_a    <= 17'd0;
         r_s1_b    <= 17'd131071;
         r_s1_chg  <= 1'b0;
         r_sin     <= 18'sd0;
         r_cos     <= 18'sd131071;
         r_valid   <= 1'b0;
      end else begin
         r_s1_quad <= r_angle[ANGLE_BITS-1 -: 2];
         r_s1_a    <= w_a;
         r_s1_b    <= w_b;
         r_s1_chg  <= r_angle_chg;
         r_sin     <= w_sin;
         r_cos     <= w_cos;
         r_valid   <= r_s1_chg;
      end
   end

   assign w_pa = {1'b0, r_s1_a};
   assign w_pb = {1'b0, r_s1_b};

   always_comb begin
      w_sin = w_pa;
      w_cos = w_pb;
      case (r_s1_quad)
         2'd0: begin w_sin = w_pa;  w_cos = w_pb;  end
         2'd1: begin w_sin = w_pb;  w_cos = -w_pa; end
         2'd2: begin w_sin = -w_pa; w_cos = -w_pb; end
         default: begin w_sin = -w_pb; w_cos = w_pa; end
      endcase
   end

   assign angle      = r_angle;
   assign sin_val    = r_sin;
   assign cos_val    = r_cos;
   assign trig_valid = r_valid;

endmodule

// File: tb/tb_rotate_ship.sv
// Bench for rotate_ship: real-math reference of heading, timing and trig outputs, checked every clock.
module tb_rotate_ship;

   localparam int DIV    = 4;
   localparam int CR     = 400;
   localparam int BR     = 10;
   localparam int PERIOD = DIV * (CR / DIV / BR);
   localparam int N      = 64;
`ifdef ROTATE_AUTO_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic               collision;
   logic               left;
   logic               right;
   logic [5:0]         angle;
   logic signed [17:0] sin_val;
   logic signed [17:0] cos_val;
   logic               trig_valid;

   int total = 0;
   int bad   = 0;
   int m_phase, m_ang, m_rep, m_ticks, n_valid, nv;
   int h_ang[4];
   bit h_rst[4];
   int seq[5];

   rotate_ship #(
      .ANGLE_BITS(6), .BTN_RATE(BR), .DIVIDER(DIV), .CLK_RATE(CR)
   ) dut (
      .clk(clk), .reset(reset), .collision(collision), .left(left), .right(right),
      .angle(angle), .sin_val(sin_val), .cos_val(cos_val), .trig_valid(trig_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
      longint d;
      total++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_trig(input int a, input bit is_cos);
      real th, v;
      int  r;
      th = 2.0 * 3.14159265358979 * a / N;
      v  = 131072.0 * (is_cos ? $cos(th) : $sin(th));
      r  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      if (r > 131071) r = 131071;
      if (r < -131071) r = -131071;
      return r;
   endfunction

   // One clock: advance the reference with the inputs present at the edge, then compare.
   task automatic tick_edge();
      bit tk;
      int d, ea;
      bit ev;
      @(posedge clk);
      #1;
      if (reset) begin
         m_phase = 0;
         m_ang   = 0;
         m_rep   = 0;
      end else begin
         tk      = (m_phase == PERIOD - 1);
         m_phase = (m_phase + 1) % PERIOD;
         if (tk) m_ticks++;
         if (collision) begin
            m_ang = 0;
            m_rep = 0;
         end else if (tk) begin
            if (left != right) begin
               d     = (ACCEL && m_rep == 3) ? 2 : 1;
               m_ang = left ? (m_ang + d) % N : (m_ang + N - d) % N;
               if (m_rep < 3) m_rep++;
            end else begin
               m_rep = 0;
            end
         end
      end
      for (int k = 3; k > 0; k--) begin
         h_ang[k] = h_ang[k-1];
         h_rst[k] = h_rst[k-1];
      end
      h_ang[0] = m_ang;
      h_rst[0] = reset;
      ea = (h_rst[0] || h_rst[1]) ? 0 : h_ang[2];
      ev = !h_rst[0] && !h_rst[1] && !h_rst[2] && (h_ang[2] != h_ang[3]);
      if (trig_valid) n_valid++;
      check("angle", angle, m_ang);
      check("sin", sin_val, ref_trig(ea, 1'b0), 2);
      check("cos", cos_val, ref_trig(ea, 1'b1), 2);
      check("valid", trig_valid, ev);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick_edge();
   endtask

   task automatic run_steps(input int k);
      int start;
      start = m_ticks;
      for (int i = 0; i < (k + 1) * PERIOD && (m_ticks - start) < k; i++) tick_edge();
   endtask

   task automatic run_to_tick();
      for (int i = 0; i < PERIOD && m_phase != PERIOD - 1; i++) tick_edge();
   endtask

   // Single steps separated by a released step, so the repeat counter never builds up.
   task automatic walk(input logic l, input logic r, input int k);
      for (int i = 0; i < k; i++) begin
         left  = l;
         right = r;
         run_steps(1);
         left  = 1'b0;
         right = 1'b0;
         run_steps(1);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      run(1);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; collision = 1'b0; left = 1'b0; right = 1'b0;
      m_phase = 0; m_ang = 0; m_rep = 0; m_ticks = 0; n_valid = 0;
      for (int k = 0; k < 4; k++) begin
         h_ang[k] = 0;
         h_rst[k] = 1'b1;
      end
      if (ACCEL) seq = '{1, 2, 3, 5, 7};
      else seq = '{1, 2, 3, 4, 5};

      run(3);
      check("rst_angle", angle, 0);
      check("rst_sin", sin_val, 0);
      check("rst_cos", cos_val, 131071);
      check("rst_valid", trig_valid, 0);

      reset = 1'b0;
      nv = n_valid;
      run(200);
      check("idle_angle", angle, 0);
      check("idle_cos", cos_val, 131071);
      check("idle_pulses", n_valid - nv, 0);

      walk(1'b1, 1'b0, 8);
      check("l8_angle", angle, 8);
      check("l8_sin", sin_val, 92682, 2);
      check("l8_cos", cos_val, 92682, 2);

      pulse_reset();
      walk(1'b1, 1'b0, 16);
      check("l16_angle", angle, 16);
      check("l16_sin", sin_val, 131071);
      check("l16_cos", cos_val, 0, 2);
      walk(1'b1, 1'b0, 16);
      check("l32_angle", angle, 32);
      check("l32_sin", sin_val, 0, 2);
      check("l32_cos", cos_val, -131071);

      pulse_reset();
      walk(1'b0, 1'b1, 1);
      check("r1_angle", angle, 63);
      check("r1_sin", sin_val, -12847, 2);
      check("r1_cos", cos_val, 130440, 2);
      nv = n_valid;
      left = 1'b1; right = 1'b1;
      run_steps(3);
      left = 1'b0; right = 1'b0;
      run(3);
      check("both_angle", angle, 63);
      check("both_pulses", n_valid - nv, 0);

      pulse_reset();
      walk(1'b1, 1'b0, 40);
      check("pre_col_angle", angle, 40);
      left = 1'b1;
      run_to_tick();
      collision = 1'b1;
      run(1);
      collision = 1'b0;
      left = 1'b0;
      check("col_angle", angle, 0);
      run(2);
      check("col_sin", sin_val, 0);
      check("col_cos", cos_val, 131071);

      left = 1'b1;
      run_steps(1);
      left = 1'b0;
      check("pre_rst_angle", angle, 1);
      reset = 1'b1;
      run(1);
      reset = 1'b0;
      nv = n_valid;
      check("mid_rst_angle", angle, 0);
      check("mid_rst_sin", sin_val, 0);
      check("mid_rst_cos", cos_val, 131071);
      check("mid_rst_valid", trig_valid, 0);
      run(5);
      check("mid_rst_pulses", n_valid - nv, 0);

      pulse_reset();
      left = 1'b1;
      for (int j = 0; j < 5; j++) begin
         run_steps(1);
         check("hold_seq", angle, seq[j]);
      end
      left = 1'b0;

      for (int s = 0; s < 100; s++) begin
         int len, btn;
         btn   = $urandom_range(0, 3);
         left  = btn[0];
         right = btn[1];
         len   = $urandom_range(1, 60);
         for (int c = 0; c < len; c++) begin
            collision = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            run(1);
         end
      end
      collision = 1'b0; reset = 1'b0; left = 1'b0; right = 1'b0;
      run(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
